// File: rtl/inst_sram_responder.sv
// Responder end of the SRAM-like bus: word memory behind an in-order response FIFO
// with a fixed minimum latency. Optional random stalls: define SRAM_RESP_RAND_DELAY_EN.
module inst_sram_responder #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(RD_LAT + 1);
  localparam int WORDS = 1 << ADDR_W;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] LAT_C   = AGE_W'(RD_LAT);
  localparam logic [AGE_W-1:0] AGE_NEW = AGE_W'(1);

  // Backing store and FIFO payload
  logic [31:0]       mem_q      [WORDS];
  logic              ent_wr_q   [DEPTH];
  logic [31:0]       ent_data_q [DEPTH];

  // FIFO control
  logic [AGE_W-1:0]  age_q [DEPTH];
  logic [AGE_W-1:0]  age_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic              addr_ok;
  logic              accept;
  logic              retire;
  logic [ADDR_W-1:0] idx;
  logic              unused_bits;

  assign idx         = inst_sram_addr[ADDR_W+1:2];
  assign unused_bits = ^{inst_sram_size, inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0]};

`ifdef SRAM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`endif

  // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    addr_ok = resetn && (count_q < DEPTH_C);
    retire  = resetn && (count_q != '0) && (age_q[rd_ptr_q] == LAT_C);
`ifdef SRAM_RESP_RAND_DELAY_EN
    addr_ok = addr_ok && lfsr_q[0];
    retire  = retire  && lfsr_q[1];
`endif
    accept   = inst_sram_req && addr_ok;
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = retire ? rd_ptr_q + 1'b1 : rd_ptr_q;

    unique case ({accept, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Ages saturate at RD_LAT; a fresh entry starts at 1 so it is due RD_LAT cycles after acceptance.
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = (age_q[i] == LAT_C) ? age_q[i] : age_q[i] + 1'b1;
    end
    if (accept) age_d[wr_ptr_q] = AGE_NEW;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

  // NOTE: memory and FIFO payload are deliberately not reset; only pointers, count and ages are.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_wr_q[wr_ptr_q]   <= inst_sram_wr;
      ent_data_q[wr_ptr_q] <= inst_sram_wr ? 32'h0 : mem_q[idx];
      if (inst_sram_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (inst_sram_wstrb[b]) mem_q[idx][8*b +: 8] <= inst_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  assign inst_sram_addr_ok = addr_ok;
  assign inst_sram_data_ok = retire;
  assign inst_sram_rdata   = (retire && !ent_wr_q[rd_ptr_q]) ? ent_data_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: two instances (RD_LAT 1 and 8) checked against a
// queue-based model of acceptance order, memory contents and response timing.
module tb_inst_sram_responder;

  localparam int DEPTH = 4;
  localparam int LAT0  = 1;
  localparam int LAT1  = 8;

  typedef struct packed {
    logic [31:0] data;
    int          early;
    int          due;
  } exp_t;

  logic        clk    = 1'b0;
  logic        resetn = 1'b1;
  logic        req   [2];
  logic        wr    [2];
  logic [1:0]  size  [2];
  logic [31:0] addr  [2];
  logic [3:0]  wstrb [2];
  logic [31:0] wdata [2];
  logic        aok   [2];
  logic        dok   [2];
  logic [31:0] rdata [2];

  // Reference model state
  logic [31:0] ref_mem [2][4096];
  exp_t        ebuf    [2][8];
  int          ehead   [2];
  int          ecnt    [2];
  int          last_due[2];
  int          max_cnt [2];
  int          resp_cnt[2];
  int          cyc;

  // Per-cycle observations
  logic        o_aok [2];
  logic        o_dok [2];
  logic [31:0] o_rd  [2];
  bit          o_acc [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_sram_responder #(.ADDR_W(12), .DEPTH(DEPTH), .RD_LAT(LAT0)) dut_l1 (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(req[0]), .inst_sram_wr(wr[0]), .inst_sram_size(size[0]),
    .inst_sram_addr(addr[0]), .inst_sram_wstrb(wstrb[0]), .inst_sram_wdata(wdata[0]),
    .inst_sram_addr_ok(aok[0]), .inst_sram_data_ok(dok[0]), .inst_sram_rdata(rdata[0])
  );

  inst_sram_responder #(.ADDR_W(12), .DEPTH(DEPTH), .RD_LAT(LAT1)) dut_l8 (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(req[1]), .inst_sram_wr(wr[1]), .inst_sram_size(size[1]),
    .inst_sram_addr(addr[1]), .inst_sram_wstrb(wstrb[1]), .inst_sram_wdata(wdata[1]),
    .inst_sram_addr_ok(aok[1]), .inst_sram_data_ok(dok[1]), .inst_sram_rdata(rdata[1])
  );

  // One bus cycle: sample both instances at the falling edge, score them, advance.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [11:0] ix;
      logic [31:0] w;
      int          lat;
      bit          exp_aok;
      bit          late_ok;
      exp_t        e;
      lat = (k == 0) ? LAT0 : LAT1;
      if (!resetn) begin
        ecnt[k]  = 0;
        ehead[k] = 0;
      end
      o_aok[k] = aok[k];
      o_dok[k] = dok[k];
      o_rd[k]  = rdata[k];
      o_acc[k] = (req[k] === 1'b1) && (aok[k] === 1'b1);
`ifndef SRAM_RESP_RAND_DELAY_EN
      exp_aok = resetn && (ecnt[k] < DEPTH);
      checks++;
      if (aok[k] !== exp_aok) begin
        errors++;
        $display("FAIL addr_ok inst%0d cyc=%0d: got %b want %b", k, cyc, aok[k], exp_aok);
      end
`else
      exp_aok = 1'b0;
      if (!resetn) begin
        checks++;
        if (aok[k] !== exp_aok) begin
          errors++;
          $display("FAIL addr_ok_in_reset inst%0d cyc=%0d: got %b want 0", k, cyc, aok[k]);
        end
      end
`endif
      checks++;
      if (dok[k] === 1'b1) begin
        resp_cnt[k]++;
        if (ecnt[k] == 0) begin
          errors++;
          $display("FAIL unexpected_data_ok inst%0d cyc=%0d: got data_ok=1 want 0", k, cyc);
        end else begin
          e        = ebuf[k][ehead[k]];
          ehead[k] = (ehead[k] + 1) % 8;
          ecnt[k]--;
          if (rdata[k] !== e.data) begin
            errors++;
            $display("FAIL resp_data inst%0d cyc=%0d: got %h want %h", k, cyc, rdata[k], e.data);
          end
          checks++;
`ifndef SRAM_RESP_RAND_DELAY_EN
          late_ok = (cyc == e.due);
`else
          late_ok = (cyc >= e.early);
`endif
          if (!late_ok) begin
            errors++;
            $display("FAIL resp_cycle inst%0d: got cycle %0d want %0d (earliest %0d)", k, cyc, e.due, e.early);
          end
        end
      end else if (dok[k] !== 1'b0 || rdata[k] !== 32'h0) begin
        errors++;
        $display("FAIL idle_outputs inst%0d cyc=%0d: got data_ok=%b rdata=%h want 0/0", k, cyc, dok[k], rdata[k]);
      end
      if (o_acc[k]) begin
        ix = addr[k][13:2];
        if (wr[k]) begin
          w = ref_mem[k][ix];
          for (int b = 0; b < 4; b++) if (wstrb[k][b]) w[8*b +: 8] = wdata[k][8*b +: 8];
          ref_mem[k][ix] = w;
          e.data = 32'h0;
        end else begin
          e.data = ref_mem[k][ix];
        end
        e.early     = cyc + lat;
        e.due       = (cyc + lat > last_due[k] + 1) ? cyc + lat : last_due[k] + 1;
        last_due[k] = e.due;
        if (ecnt[k] < 8) begin
          ebuf[k][(ehead[k] + ecnt[k]) % 8] = e;
          ecnt[k]++;
        end
        if (ecnt[k] > max_cnt[k]) max_cnt[k] = ecnt[k];
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int c);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wstrb[k] = s; wdata[k] = d; size[k] = 2'd2;
    c = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (o_acc[k]) begin
        c = cyc - 1;
        break;
      end
    end
    req[k] = 1'b0;
    checks++;
    if (c < 0) begin
      errors++;
      $display("FAIL accept_timeout inst%0d: got no addr_ok in 64 cycles want accept", k);
    end
  endtask

  task automatic wait_resp(input int k, output logic [31:0] d, output int c);
    d = 32'h0;
    c = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (o_dok[k] === 1'b1) begin
        d = o_rd[k];
        c = cyc - 1;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (ecnt[0] != 0 || ecnt[1] != 0); i++) tick();
    tick();
    checks++;
    if (ecnt[0] != 0 || ecnt[1] != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d outstanding want 0/0", ecnt[0], ecnt[1]);
    end
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_aok[k] !== 1'b0 || o_dok[k] !== 1'b0 || o_rd[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got %b/%b/%h want 0/0/0", k, o_aok[k], o_dok[k], o_rd[k]);
      end
    end
    resetn = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_aok[k] !== 1'b1) begin
        errors++;
        $display("FAIL addr_ok_after_release inst%0d: got %b want 1", k, o_aok[k]);
      end
    end
  endtask

  task automatic test_init_mem();
    int c;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        issue(k, 1'b1, 32'h1fc00000 | (i << 2), 4'hF, 32'hC0DE0000 | (k << 8) | i, c);
      end
    end
    drain();
  endtask

  // Write then read back through the RD_LAT=1 instance.
  task automatic test_write_read();
    logic [31:0] wa [3];
    logic [3:0]  ws [3];
    logic [31:0] wd [3];
    logic [31:0] ra [3];
    logic [31:0] want [3];
    logic [31:0] d;
    int          ca, cr;
    wa = '{32'h1fc00000, 32'h1fc00000, 32'hBFC00004};
    ws = '{4'hF, 4'b0010, 4'hF};
    wd = '{32'h12345678, 32'h0000AB00, 32'hDEADBEEF};
    ra = '{32'h1fc00000, 32'h1fc00000, 32'h1FC00004};
    want = '{32'h12345678, 32'h1234AB78, 32'hDEADBEEF};
    for (int t = 0; t < 3; t++) begin
      issue(0, 1'b1, wa[t], ws[t], wd[t], ca);
      wait_resp(0, d, cr);
      checks++;
      if (cr < 0 || d !== 32'h0) begin
        errors++;
        $display("FAIL write_resp case%0d: got cycle %0d rdata %h want response with rdata 0", t, cr, d);
      end
`ifndef SRAM_RESP_RAND_DELAY_EN
      checks++;
      if (cr != ca + LAT0) begin
        errors++;
        $display("FAIL write_latency case%0d: got cycle %0d want %0d", t, cr, ca + LAT0);
      end
`endif
      issue(0, 1'b0, ra[t], 4'h0, 32'h0, ca);
      wait_resp(0, d, cr);
      checks++;
      if (cr < 0 || d !== want[t]) begin
        errors++;
        $display("FAIL read_back case%0d: got cycle %0d rdata %h want %h", t, cr, d, want[t]);
      end
    end
    drain();
  endtask

  // Reads held continuously on the RD_LAT=8 instance until it fills.
  task automatic test_full_lat8();
    bit aok_hist [10];
    int first_dok;
    int n_acc;
    first_dok = -1;
    n_acc     = 0;
    for (int i = 0; i < 10; i++) begin
      req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2;
      addr[1] = 32'h1fc00000 | ((2 + n_acc) << 2);
      tick();
      aok_hist[i] = o_aok[1];
      if (o_acc[1]) n_acc++;
      if (o_dok[1] === 1'b1 && first_dok < 0) first_dok = i;
    end
    req[1] = 1'b0;
`ifndef SRAM_RESP_RAND_DELAY_EN
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (aok_hist[i] !== ((i < 4) || (i == 9))) begin
        errors++;
        $display("FAIL full_addr_ok rel_cycle %0d: got %b want %b", i, aok_hist[i], (i < 4) || (i == 9));
      end
    end
    checks++;
    if (first_dok != 8) begin
      errors++;
      $display("FAIL full_first_data_ok: got rel_cycle %0d want 8", first_dok);
    end
`endif
    drain();
  endtask

  task automatic test_back_to_back();
    int n_acc, n_resp, peak;
    n_acc = 0; n_resp = 0; peak = 0;
    for (int i = 0; i < 12; i++) begin
      req[0] = 1'b1; wr[0] = 1'b0; size[0] = 2'd2;
      addr[0] = 32'h1fc00000 | ((i % 16) << 2);
      tick();
      if (o_acc[0]) n_acc++;
      if (o_dok[0] === 1'b1) n_resp++;
      if (ecnt[0] > peak) peak = ecnt[0];
    end
    req[0] = 1'b0;
`ifndef SRAM_RESP_RAND_DELAY_EN
    checks++;
    if (n_acc != 12 || n_resp != 11 || peak > 1) begin
      errors++;
      $display("FAIL back_to_back: got acc=%0d resp=%0d peak=%0d want 12/11/<=1", n_acc, n_resp, peak);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2;
      addr[1] = 32'h1fc00000 | ((8 + i) << 2);
      tick();
    end
    req[1] = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    if (o_dok[1] === 1'b1) seen++;
    tick();
    if (o_dok[1] === 1'b1) seen++;
    resetn = 1'b1;
    tick();
    checks++;
    if (o_aok[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_addr_ok: got %b want 1", o_aok[1]);
    end
    if (o_dok[1] === 1'b1) seen++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_dok[1] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_stale: got %0d data_ok want 0", seen);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      int          n_acc, base;
      logic [31:0] r;
      logic [3:0]  ix;
      n_acc      = 0;
      base       = resp_cnt[k];
      max_cnt[k] = 0;
      for (int i = 0; i < 20000 && n_acc < 1000; i++) begin
        r  = $urandom();
        ix = 4'($urandom_range(0, 15));
        req[k]   = ($urandom_range(0, 4) != 0);
        wr[k]    = r[2];
        size[k]  = 2'($urandom_range(0, 2));
        addr[k]  = {r[31:14], 8'h00, ix, r[1:0]};
        wstrb[k] = 4'($urandom());
        wdata[k] = $urandom();
        tick();
        if (o_acc[k]) n_acc++;
      end
      req[k] = 1'b0;
      drain();
      checks++;
      if (n_acc != 1000 || resp_cnt[k] - base != 1000) begin
        errors++;
        $display("FAIL random_count inst%0d: got acc=%0d resp=%0d want 1000/1000", k, n_acc, resp_cnt[k] - base);
      end
      checks++;
      if (max_cnt[k] > DEPTH) begin
        errors++;
        $display("FAIL random_occupancy inst%0d: got %0d want <=%0d", k, max_cnt[k], DEPTH);
      end
    end
  endtask

  initial begin
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd2; addr[k] = '0; wstrb[k] = '0; wdata[k] = '0;
      ehead[k] = 0; ecnt[k] = 0; last_due[k] = 0; max_cnt[k] = 0; resp_cnt[k] = 0;
    end
    test_reset();
    test_init_mem();
    test_write_read();
    test_full_lat8();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_sram_responder.md
# inst_sram_responder

Slave-side model of the team's SRAM-like bus: accepts `req`/`addr_ok` address handshakes from a pipeline fetch or memory stage and returns in-order `data_ok`/`rdata` responses from an internal word-addressed memory. It is the responder end of the `inst_sram_*` interface driven by the IF stage. It sits between `mycpu_top` and the simulation environment, and can also act as the far end of the data-side port. It gives fetch-stage verification a configurable-latency, multiple-outstanding target.

## Interface
- `ADDR_W`, 12: word-index bits; memory holds 2^ADDR_W 32-bit words.
- `DEPTH`, 4: maximum outstanding accepted-but-unanswered requests; power of two, ≥2.
- `RD_LAT`, 1: minimum cycles from address acceptance to `data_ok`; ≥1.
- `clk` in 1: clock, all state on rising edge.
- `resetn` in 1: one clock; reset is asynchronous and active-low.
- `inst_sram_req` in 1: request valid.
- `inst_sram_wr` in 1: 1 = write, 0 = read.
- `inst_sram_size` in 2: 0 byte, 1 half, 2 word.
- `inst_sram_addr` in 32: byte address.
- `inst_sram_wstrb` in 4: write byte enables.
- `inst_sram_wdata` in 32: write data.
- `inst_sram_addr_ok` out 1: request accepted this cycle when high together with `req`.
- `inst_sram_data_ok` out 1: response valid this cycle.
- `inst_sram_rdata` out 32: read data; valid only with `data_ok`.

## Operation
- Index = `addr[ADDR_W+1:2]`. Upper address bits and `addr[1:0]` are ignored. `size` does not affect indexing.
- Accept = `req & addr_ok`. `addr_ok` = `resetn & (count < DEPTH)`. `addr_ok` does not depend on `req`, and there is no same-cycle bypass from a retiring entry.
- On accept of a write: each byte lane with `wstrb[i]`=1 gets `wdata[8i+7:8i]` at that clock edge. Other lanes are unchanged. `wstrb`=0 writes nothing.
- On accept of a read: the word is read at that edge, after any same-edge write is excluded, and stored in the entry. Read data is captured at accept, so read-after-write ordering follows acceptance order.
- Each accept pushes a FIFO entry: {wr, data[31:0], age counter}. The age counter saturates at RD_LAT.
- The head entry retires, asserting `data_ok` for one cycle, when its age equals RD_LAT. At most one response per cycle, strictly in acceptance order.
- Writes also retire with `data_ok`. `rdata` is 0 for writes.
- When `data_ok`=0, `rdata`=0.
- The master has no back-pressure on responses. Every accepted request produces exactly one `data_ok`, including requests the master later cancels after a flush.
- count: +1 on accept, −1 on retire, unchanged on both or neither.
- Pointers wrap modulo DEPTH.

## Timing
- Request accepted at edge T → earliest `data_ok` in cycle T+RD_LAT. When not blocked by an older head, `data_ok` comes exactly at T+RD_LAT.
- With RD_LAT=1 and `req` held, one accept and one response occur every cycle; count stays ≤1.
- Full (count=DEPTH): `addr_ok`=0. If the head retires that cycle, `addr_ok` rises the following cycle.
- Empty: `data_ok`=0.
- Simultaneous accept and retire are both honoured in the same cycle.
- `resetn` low: asynchronously clears pointers, count, and ages. Outputs are immediately `addr_ok`=0, `data_ok`=0, `rdata`=0.
- Reset mid-operation: outstanding entries are discarded, and no stale `data_ok` appears after release. Memory contents are not reset.
- First cycle after release: `addr_ok`=1.

## Configuration
- `SRAM_RESP_RAND_DELAY_EN`:
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset value 16'hACE1) advances every cycle. `addr_ok` is additionally ANDed with `lfsr[0]`, and head retirement is additionally gated by `lfsr[1]`. Ordering and one-response-per-request rules still hold.
  - Undefined: no LFSR is present, and timing is exactly as specified above.

## Test plan
- Word write: addr 0x1fc00000, wstrb 4'hF, wdata 0x12345678 (accept cycle 0) → `data_ok` in cycle 1 with rdata 0. Then a read of the same address accepted in cycle 2 → `data_ok` in cycle 3 with rdata 0x12345678.
- Byte write: wstrb 4'b0010, wdata 0x0000AB00 to the same word, then a read → rdata 0x1234AB78.
- RD_LAT=8, DEPTH=4, `req` held for reads:
  - accepts in cycles 0–3;
  - `addr_ok`=0 in cycles 4–8;
  - first `data_ok` in cycle 8;
  - `addr_ok`=1 in cycle 9;
  - responses in acceptance order.
- Aliasing: write 0xDEADBEEF to 0xBFC00004, read 0x1FC00004 (same index) → 0xDEADBEEF.
- Two reads outstanding (RD_LAT=8), then `resetn` low in cycle 3 → `data_ok` stays 0 through release and for 10 cycles after. `addr_ok`=1 in the first cycle after release.
- Macro defined: 1000 random read/write requests, with a scoreboard checking data and order → zero mismatches, exactly 1000 `data_ok`, and count never exceeding DEPTH.
